// File: rtl/menu_controller_pkg.sv
// Shared state codes, default timing values and counter-width helper for the
// greenhouse front-panel menu controller.
package menu_controller_pkg;

    localparam logic [3:0] ST_TEMP_SEL = 4'd0;
    localparam logic [3:0] ST_HUM_SEL  = 4'd1;
    localparam logic [3:0] ST_IDLE     = 4'd2;

    localparam int DEF_DEBOUNCE_CYCLES = 250000;
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_PERIOD   = 5000000;
    localparam int DEF_IDLE_TIMEOUT    = 500000000;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
    } btn_pulse_t;

    // Bits needed to hold a counter that must reach n.
    function automatic int cntWidth(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/menu_controller_if.sv
// Front-panel bundle: raw buttons in, menu selection and setpoints out.
interface menu_controller_if;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic [3:0] state;
    logic [11:0] set_temp;
    logic [7:0] set_hum;
    logic       settings_changed;

    modport master (
        output btn_up, btn_down, btn_left, btn_right,
        input  state, set_temp, set_hum, settings_changed
    );

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right,
        output state, set_temp, set_hum, settings_changed
    );
endinterface

// File: rtl/menu_controller_button_conditioner.sv
// One push-button: 2-FF synchronizer, debounce, rising-edge press pulse and
// optional hold-to-repeat pulses merged onto a single pulse output.
module button_conditioner
    import menu_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic pulse_o
);
    localparam int DW = cntWidth(DEBOUNCE_CYCLES);
    localparam int RW = cntWidth((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RPT_DELAY  = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RPT_PERIOD = RW'(REPEAT_PERIOD);

    logic          syncMeta_q, syncOut_q;
    logic          level_q, level_d, levelPrev_q;
    logic [DW-1:0] debCnt_q, debCnt_d;
    logic [RW-1:0] rptCnt_q, rptCnt_d;
    logic          rptArmed_q, rptArmed_d;
    logic          press, repeatHit;

    // The accepted level flips only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        debCnt_d = '0;
        level_d  = level_q;
        if (syncOut_q != level_q) begin
            if (debCnt_q == DEB_LAST) begin
                level_d = syncOut_q;
            end else begin
                debCnt_d = debCnt_q + 1'b1;
            end
        end
    end

    assign press = level_q & ~levelPrev_q;

    always_comb begin
        rptCnt_d   = '0;
        rptArmed_d = 1'b0;
        repeatHit  = 1'b0;
        if (REPEAT_EN && level_q) begin
            repeatHit  = rptArmed_q ? (rptCnt_q == RPT_PERIOD) : (rptCnt_q == RPT_DELAY);
            rptArmed_d = rptArmed_q | repeatHit;
            rptCnt_d   = repeatHit ? RW'(1) : rptCnt_q + 1'b1;
        end
    end

    assign pulse_o = press | repeatHit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncMeta_q  <= 1'b0;
            syncOut_q   <= 1'b0;
            level_q     <= 1'b0;
            levelPrev_q <= 1'b0;
            debCnt_q    <= '0;
            rptCnt_q    <= '0;
            rptArmed_q  <= 1'b0;
        end else begin
            syncMeta_q  <= btn_i;
            syncOut_q   <= syncMeta_q;
            level_q     <= level_d;
            levelPrev_q <= level_q;
            debCnt_q    <= debCnt_d;
            rptCnt_q    <= rptCnt_d;
            rptArmed_q  <= rptArmed_d;
        end
    end

endmodule

// File: rtl/menu_controller.sv
// Front-panel menu controller: field selection FSM with inactivity timeout and
// two saturating setpoint registers driven by conditioned push-buttons.
module menu_controller
    import menu_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int IDLE_TIMEOUT    = DEF_IDLE_TIMEOUT,
    parameter int TEMP_MIN        = 32,
    parameter int TEMP_MAX        = 120,
    parameter int TEMP_RESET      = 72,
    parameter int HUM_MIN         = 0,
    parameter int HUM_MAX         = 99,
    parameter int HUM_RESET       = 50
) (
    input logic             clk,
    input logic             rst_n,
    menu_controller_if.slave bus
);
    localparam int IW = cntWidth(IDLE_TIMEOUT);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);
    localparam logic [11:0] T_MIN = 12'(TEMP_MIN);
    localparam logic [11:0] T_MAX = 12'(TEMP_MAX);
    localparam logic [11:0] T_RST = 12'(TEMP_RESET);
    localparam logic [7:0]  H_MIN = 8'(HUM_MIN);
    localparam logic [7:0]  H_MAX = 8'(HUM_MAX);
    localparam logic [7:0]  H_RST = 8'(HUM_RESET);

    logic          rstMeta_q, rstSync_n;
    btn_pulse_t    pulse;
    logic [3:0]    state_q, state_d, lastSel_q, lastSel_d;
    logic [IW-1:0] idleCnt_q, idleCnt_d;
    logic [11:0]   temp_q, temp_d;
    logic [7:0]    hum_q, hum_d;
    logic          changed_q, changed_d;
    logic          anyPulse, navAny, navHit, incHit, decHit;

    // Reset asserts immediately but releases two clocks later, aligned to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstMeta_q <= 1'b0;
            rstSync_n <= 1'b0;
        end else begin
            rstMeta_q <= 1'b1;
            rstSync_n <= rstMeta_q;
        end
    end

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b1))
        uUp    (.clk(clk), .rst_n(rstSync_n), .btn_i(bus.btn_up),    .pulse_o(pulse.up));
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b1))
        uDown  (.clk(clk), .rst_n(rstSync_n), .btn_i(bus.btn_down),  .pulse_o(pulse.down));
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b0))
        uLeft  (.clk(clk), .rst_n(rstSync_n), .btn_i(bus.btn_left),  .pulse_o(pulse.left));
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b0))
        uRight (.clk(clk), .rst_n(rstSync_n), .btn_i(bus.btn_right), .pulse_o(pulse.right));

    // Any nav pulse drops a concurrent adjust; opposing pulses cancel each other.
    always_comb begin
        state_d   = state_q;
        lastSel_d = lastSel_q;
        idleCnt_d = idleCnt_q;
        temp_d    = temp_q;
        hum_d     = hum_q;
        changed_d = 1'b0;
        anyPulse  = |pulse;
        navAny    = pulse.left | pulse.right;
        navHit    = pulse.left ^ pulse.right;
        incHit    = pulse.up & ~pulse.down & ~navAny;
        decHit    = pulse.down & ~pulse.up & ~navAny;
        if (state_q == ST_IDLE) begin
            if (anyPulse) begin
                state_d   = lastSel_q;
                idleCnt_d = '0;
            end
        end else if (!anyPulse && idleCnt_q == IDLE_LAST) begin
            state_d   = ST_IDLE;
            lastSel_d = state_q;
            idleCnt_d = '0;
        end else begin
            idleCnt_d = anyPulse ? '0 : idleCnt_q + 1'b1;
            if (navHit) begin
                state_d = (state_q == ST_TEMP_SEL) ? ST_HUM_SEL : ST_TEMP_SEL;
            end else if (state_q == ST_TEMP_SEL) begin
                if (incHit && temp_q < T_MAX) begin
                    temp_d    = temp_q + 1'b1;
                    changed_d = 1'b1;
                end else if (decHit && temp_q > T_MIN) begin
                    temp_d    = temp_q - 1'b1;
                    changed_d = 1'b1;
                end
            end else begin
                if (incHit && hum_q < H_MAX) begin
                    hum_d     = hum_q + 1'b1;
                    changed_d = 1'b1;
                end else if (decHit && hum_q > H_MIN) begin
                    hum_d     = hum_q - 1'b1;
                    changed_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstSync_n) begin
        if (!rstSync_n) begin
            state_q   <= ST_TEMP_SEL;
            lastSel_q <= ST_TEMP_SEL;
            idleCnt_q <= '0;
            temp_q    <= T_RST;
            hum_q     <= H_RST;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lastSel_q <= lastSel_d;
            idleCnt_q <= idleCnt_d;
            temp_q    <= temp_d;
            hum_q     <= hum_d;
            changed_q <= changed_d;
        end
    end

    assign bus.state            = state_q;
    assign bus.set_temp         = temp_q;
    assign bus.set_hum          = hum_q;
    assign bus.settings_changed = changed_q;

endmodule

// File: tb/tb_menu_controller.sv
// Directed scoreboard bench for menu_controller with shortened timing parameters.
module tb_menu_controller;

    localparam int DEB        = 4;
    localparam int RPT_DELAY  = 20;
    localparam int RPT_PERIOD = 5;
    localparam int IDLE_TO    = 100;

    localparam logic [3:0] S_TEMP = 4'd0;
    localparam logic [3:0] S_HUM  = 4'd1;
    localparam logic [3:0] S_IDLE = 4'd2;

    localparam logic [3:0] B_UP    = 4'b1000;
    localparam logic [3:0] B_DOWN  = 4'b0100;
    localparam logic [3:0] B_RIGHT = 4'b0001;

    typedef struct {
        string      tag;
        logic [3:0] st;
        int         temp;
        int         hum;
        int         changes;
    } expect_t;

    logic    clk = 1'b0;
    logic    rst_n = 1'b0;
    int      checks = 0;
    int      errors = 0;
    int      changedCount = 0;
    logic [3:0] mState, mLast;
    int      mTemp, mHum, mChanges;
    expect_t sbQueue[$];

    menu_controller_if bus();

    menu_controller #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY(RPT_DELAY),
        .REPEAT_PERIOD(RPT_PERIOD),
        .IDLE_TIMEOUT(IDLE_TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.settings_changed === 1'b1) changedCount++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic setButtons(input logic [3:0] m);
        bus.btn_up    = m[3];
        bus.btn_down  = m[2];
        bus.btn_left  = m[1];
        bus.btn_right = m[0];
    endtask

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Reference behaviour of one accepted pulse set {up,down,left,right}.
    task automatic modelPulse(input logic [3:0] m);
        if (mState == S_IDLE) begin
            mState = mLast;
        end else if (m[1] ^ m[0]) begin
            mState = (mState == S_TEMP) ? S_HUM : S_TEMP;
        end else if (!(m[1] | m[0]) && (m[3] ^ m[2])) begin
            if (mState == S_TEMP) begin
                if (m[3] && mTemp < 120) begin mTemp++; mChanges++; end
                else if (m[2] && mTemp > 32) begin mTemp--; mChanges++; end
            end else begin
                if (m[3] && mHum < 99) begin mHum++; mChanges++; end
                else if (m[2] && mHum > 0) begin mHum--; mChanges++; end
            end
        end
    endtask

    // Accepted level stays high as long as the raw press; repeats at DELAY, DELAY+PERIOD, ...
    function automatic int pulseCount(input int hold);
        int n;
        if (hold < DEB) return 0;
        n = 1;
        if (hold - 1 >= RPT_DELAY) n += 1 + (hold - 1 - RPT_DELAY) / RPT_PERIOD;
        return n;
    endfunction

    task automatic pushExpect(input string tag);
        expect_t e;
        e.tag     = tag;
        e.st      = mState;
        e.temp    = mTemp;
        e.hum     = mHum;
        e.changes = mChanges;
        sbQueue.push_back(e);
    endtask

    task automatic applyStimulus(input string tag, input logic [3:0] m, input int hold);
        int n;
        n = pulseCount(hold);
        for (int p = 0; p < n; p++) modelPulse((p == 0) ? m : (m & (B_UP | B_DOWN)));
        pushExpect(tag);
        setButtons(m);
        tick(hold);
        setButtons(4'b0000);
        tick(DEB + 4);
    endtask

    task automatic checkOutput();
        expect_t e;
        if (sbQueue.size() == 0) begin
            errors++;
            $error("[TB] FAIL scoreboard: observed=empty expected=entry");
            return;
        end
        e = sbQueue.pop_front();
        check({e.tag, "_state"},   int'(bus.state),    int'(e.st));
        check({e.tag, "_temp"},    int'(bus.set_temp), e.temp);
        check({e.tag, "_hum"},     int'(bus.set_hum),  e.hum);
        check({e.tag, "_changes"}, changedCount,       e.changes);
    endtask

    initial begin
        setButtons(4'b0000);
        mState = S_TEMP; mLast = S_TEMP; mTemp = 72; mHum = 50; mChanges = 0;
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(4);
        $display("[TB] reset values");
        pushExpect("reset");
        checkOutput();
        check("reset_changed", int'(bus.settings_changed), 0);

        $display("[TB] bounce rejection");
        applyStimulus("glitch_up", B_UP, 3);
        checkOutput();

        $display("[TB] press latency");
        setButtons(B_UP);
        tick(2 + DEB);
        check("latency_before_temp", int'(bus.set_temp), mTemp);
        check("latency_before_pulse", int'(bus.settings_changed), 0);
        tick(1);
        modelPulse(B_UP);
        check("latency_temp", int'(bus.set_temp), mTemp);
        check("latency_pulse", int'(bus.settings_changed), 1);
        tick(1);
        check("latency_pulse_end", int'(bus.settings_changed), 0);
        setButtons(4'b0000);
        tick(DEB + 4);
        pushExpect("latency");
        checkOutput();

        $display("[TB] hold and repeat");
        applyStimulus("down_once", B_DOWN, 5);
        checkOutput();
        applyStimulus("hold_down", B_DOWN, 48);
        checkOutput();

        $display("[TB] nav and saturation");
        applyStimulus("nav_right", B_RIGHT, 5);
        checkOutput();
        for (int i = 0; i < 60; i++) begin
            applyStimulus($sformatf("up_%0d", i), B_UP, 5);
            checkOutput();
        end

        $display("[TB] idle timeout");
        tick(80);
        check("idle_not_yet", int'(bus.state), int'(S_HUM));
        tick(30);
        mLast  = mState;
        mState = S_IDLE;
        pushExpect("idle");
        checkOutput();
        applyStimulus("wake_up", B_UP, 5);
        checkOutput();

        $display("[TB] simultaneous events");
        applyStimulus("hum_down", B_DOWN, 5);
        checkOutput();
        applyStimulus("up_down", B_UP | B_DOWN, 5);
        checkOutput();
        applyStimulus("right_up", B_RIGHT | B_UP, 5);
        checkOutput();

        $display("[TB] asynchronous reset mid-run");
        applyStimulus("pre_reset_up", B_UP, 5);
        checkOutput();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        mState = S_TEMP; mLast = S_TEMP; mTemp = 72; mHum = 50;
        pushExpect("async_reset");
        checkOutput();
        check("async_reset_changed", int'(bus.settings_changed), 0);
        tick(2);
        rst_n = 1'b1;
        tick(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/menu_controller.md
# menu_controller

Front-panel input controller that owns the user-settable greenhouse setpoints and the menu selection index consumed by the on-screen menu overlay. It conditions four raw push-buttons, navigates between the temperature and humidity fields, and adjusts the selected setpoint with saturation and hold-to-repeat. It drops back to an idle state, with no field highlighted, after a period of inactivity. Outputs feed the VGA menu overlay directly and the climate-control logic through `settings_changed`.

## Interface
- `DEBOUNCE_CYCLES`, 250000: cycles a synchronized button must be stable before its level is accepted (5 ms at 50 MHz).
- `REPEAT_DELAY`, 25000000: held-button cycles before the first auto-repeat pulse.
- `REPEAT_PERIOD`, 5000000: cycles between later auto-repeat pulses.
- `IDLE_TIMEOUT`, 500000000: cycles without an accepted press before entering IDLE.
- `TEMP_MIN` / `TEMP_MAX` / `TEMP_RESET`, 32 / 120 / 72: setpoint bounds and reset value, in °F.
- `HUM_MIN` / `HUM_MAX` / `HUM_RESET`, 0 / 99 / 50: humidity bounds and reset value, in %RH.

Ports:
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `btn_up`, `btn_down`, `btn_left`, `btn_right` input 1 each: raw, asynchronous, active-high buttons.
- `state` output 4: 0 = TEMP_SEL, 1 = HUM_SEL, 2 = IDLE; other codes are never driven.
- `set_temp` output 12: temperature setpoint, binary.
- `set_hum` output 8: humidity setpoint, binary.
- `settings_changed` output 1: one-cycle pulse when either setpoint value actually changes.

## Operation
- **Per-button conditioning.**
  - 2-FF synchronizer, then a debounce counter; the accepted level updates only after `DEBOUNCE_CYCLES` consecutive equal samples.
  - Rising edge of the accepted level gives a one-cycle press pulse.
  - While the accepted level stays high: one repeat pulse after `REPEAT_DELAY`, then one every `REPEAT_PERIOD`.
  - Repeat applies to up and down only; left and right produce edge pulses only.
- **State machine.**
  - TEMP_SEL: left or right pulse goes to HUM_SEL.
  - HUM_SEL: left or right pulse goes to TEMP_SEL.
  - The two fields wrap, so left and right are equivalent with two fields.
  - Any accepted pulse while in TEMP_SEL or HUM_SEL reloads the idle counter. When the counter reaches `IDLE_TIMEOUT` the block goes to IDLE and stores the last field in `last_sel`.
  - IDLE: any pulse returns to `last_sel`. That pulse is consumed and has no adjust or nav effect.
- **Adjust.**
  - An up or down pulse in TEMP_SEL adds or subtracts 1 on `set_temp`. The same in HUM_SEL acts on `set_hum`.
  - Values saturate at MIN/MAX.
  - A press at a bound changes nothing and produces no `settings_changed` pulse.
- **Simultaneous events.**
  - up and down pulses in the same cycle: no adjust.
  - left and right pulses in the same cycle: no nav.
  - A nav pulse and an adjust pulse in the same cycle: nav wins and the adjust is dropped.
  - All of these still reload the idle counter.
- **Arithmetic.** Compare against the bound before adding or subtracting, so wrap-around is impossible; internal values never leave [MIN, MAX].

## Timing
- **Reset (asynchronous assert, synchronous release):**
  - `state` = 0 (TEMP_SEL) and `last_sel` = 0.
  - `set_temp` = `TEMP_RESET`, `set_hum` = `HUM_RESET`, `settings_changed` = 0.
  - All debounce, repeat and idle counters cleared; accepted button levels = 0.
- **Reset mid-press.** A button held through reset release needs a full debounce period before it is accepted. It then produces a press pulse.
- **Latency.** Raw edge to accepted level is 2 sync cycles plus `DEBOUNCE_CYCLES`. Press pulse to `state`/`set_*` update is 1 cycle (registered outputs). `settings_changed` asserts in the same cycle the new value appears.
- **Output stability.** Outputs change only on clock edges; at most one step of ±1 per cycle.

## Structure
- Shared package holds:
  - the state codes ST_TEMP_SEL, ST_HUM_SEL, ST_IDLE as 4-bit localparams;
  - counter-width helpers derived with `$clog2` of the timing parameters.
- One sub-module, `button_conditioner` (sync, debounce, edge, optional repeat; repeat disabled by a parameter). It is instantiated four times.
- Top level contains the FSM, the idle counter and the two saturating setpoint registers.

## Test plan
Bench parameters: DEBOUNCE=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, IDLE_TIMEOUT=100.
- **Reset values:** assert `rst_n`=0 mid-run → `state`=0, `set_temp`=72, `set_hum`=50, `settings_changed`=0 immediately (asynchronous).
- **Bounce rejection and latency:** 3-cycle glitch on `btn_up` → no change. A clean press → `set_temp`=73 exactly 2+4+1 cycles after the edge, with one `settings_changed` pulse.
- **Nav and saturation:**
  - right, then 60 up presses → `state`=1, `set_hum`=99.
  - The final 11 presses cause no change and no `settings_changed` pulse.
- **Hold and repeat:** hold `btn_down` for 46 cycles past acceptance → 1 + 1 + 5 = 7 decrements, `set_temp` 72→65.
- **Idle:**
  - Idle for 100 cycles in HUM_SEL → `state`=2.
  - Then press up → `state`=1 and `set_hum` unchanged.
- **Simultaneous events:**
  - up and down together → no change.
  - right and up in the same cycle → `state` toggles and the setpoint is unchanged.
